// File: rtl/seq_div16x8.sv
// Sequential 2W/W restoring divider: one quotient bit per clock, then a single fix-up/result cycle.
// Build option SEQ_DIV_SIGNED_EN selects two's-complement operands; without it operands are unsigned.
module seq_div16x8 #(
    parameter int DIV_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*DIV_W-1:0] dividend,
    input  logic [DIV_W-1:0]   divisor,
    output logic [DIV_W-1:0]   quotient,
    output logic [DIV_W-1:0]   remainder,
    output logic               busy,
    output logic               done,
    output logic               ovf,
    output logic               dbz
);
    localparam int DVD_W = 2 * DIV_W;
    localparam int CNT_W = $clog2(DVD_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DVD_W - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] rem_q, rem_d;
    logic [DVD_W-1:0] dvd_q, dvd_d;
    logic [DIV_W-1:0] dsr_q, dsr_d;
    logic             zero_q, zero_d;
    logic [DIV_W-1:0] quot_q, quot_d;
    logic [DIV_W-1:0] rmd_q, rmd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             dbz_q, dbz_d;

    logic [DVD_W-1:0] in_dvd_mag;
    logic [DIV_W-1:0] in_dsr_mag;
    logic             in_zero;
    logic [DIV_W-1:0] fix_quot;
    logic [DIV_W-1:0] fix_rem;
    logic             fix_ovf;
    logic [DIV_W:0]   shifted;
    logic [DIV_W-1:0] trial;
    logic             fits;

    assign in_zero = (divisor == '0);

    // dvd_q doubles as the quotient register: dividend bits leave at the top, quotient bits enter at the bottom
    assign shifted = {rem_q, dvd_q[DVD_W-1]};
    assign fits    = (shifted >= {1'b0, dsr_q});
    assign trial   = shifted[DIV_W-1:0] - dsr_q;

`ifdef SEQ_DIV_SIGNED_EN
    localparam logic [DVD_W-1:0] POS_MAX = DVD_W'((1 << (DIV_W - 1)) - 1);
    localparam logic [DVD_W-1:0] NEG_MAX = DVD_W'(1 << (DIV_W - 1));
    localparam logic [DIV_W-1:0] SAT_POS = {1'b0, {(DIV_W - 1){1'b1}}};
    localparam logic [DIV_W-1:0] SAT_NEG = {1'b1, {(DIV_W - 1){1'b0}}};

    logic dvd_neg_q;
    logic dsr_neg_q;
    logic q_neg;

    assign in_dvd_mag = dividend[DVD_W-1] ? -dividend : dividend;
    assign in_dsr_mag = divisor[DIV_W-1] ? -divisor : divisor;
    assign q_neg      = dvd_neg_q ^ dsr_neg_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_neg_q <= 1'b0;
            dsr_neg_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            dvd_neg_q <= dividend[DVD_W-1];
            dsr_neg_q <= divisor[DIV_W-1];
        end
    end

    always_comb begin
        fix_ovf  = 1'b0;
        fix_quot = dvd_q[DIV_W-1:0];
        fix_rem  = rem_q;
        if (zero_q) begin
            fix_quot = dvd_neg_q ? SAT_NEG : SAT_POS;
            fix_rem  = dvd_q[DIV_W-1:0];
        end else begin
            fix_ovf = q_neg ? (dvd_q > NEG_MAX) : (dvd_q > POS_MAX);
            if (fix_ovf) begin
                fix_quot = q_neg ? SAT_NEG : SAT_POS;
            end else if (q_neg) begin
                fix_quot = -dvd_q[DIV_W-1:0];
            end
            if (dvd_neg_q) begin
                fix_rem = -rem_q;
            end
        end
    end
`else
    localparam logic [DVD_W-1:0] UMAX = DVD_W'((1 << DIV_W) - 1);

    assign in_dvd_mag = dividend;
    assign in_dsr_mag = divisor;

    always_comb begin
        fix_ovf  = !zero_q && (dvd_q > UMAX);
        fix_quot = (zero_q || fix_ovf) ? {DIV_W{1'b1}} : dvd_q[DIV_W-1:0];
        fix_rem  = zero_q ? dvd_q[DIV_W-1:0] : rem_q;
    end
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        rmd_d   = rmd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = in_zero ? FIX : CALC;
                    count_d = '0;
                    rem_d   = '0;
                    // divide-by-zero keeps the raw dividend: its low byte becomes the remainder
                    dvd_d   = in_zero ? dividend : in_dvd_mag;
                    dsr_d   = in_dsr_mag;
                    zero_d  = in_zero;
                    busy_d  = 1'b1;
                end
            end
            CALC: begin
                rem_d   = fits ? trial : shifted[DIV_W-1:0];
                dvd_d   = {dvd_q[DVD_W-2:0], fits};
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // arriving straight from IDLE (zero divisor) the count is 0: hold one cycle so latency is 2
                if (count_q == '0) begin
                    count_d = CNT_W'(1);
                end else begin
                    quot_d  = fix_quot;
                    rmd_d   = fix_rem;
                    ovf_d   = fix_ovf;
                    dbz_d   = zero_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    count_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            zero_q  <= 1'b0;
            quot_q  <= '0;
            rmd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            zero_q  <= zero_d;
            quot_q  <= quot_d;
            rmd_q   <= rmd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient  = quot_q;
    assign remainder = rmd_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ovf       = ovf_q;
    assign dbz       = dbz_q;

endmodule
